mux_sel_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 4-bit 5-to-1 result mux between five requesters.

---
 rtl/mux_sel_rr_arbiter_if.sv | 27 ++
 rtl/mux_sel_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux_sel_rr_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mux_sel_rr_arbiter_if.sv
// Request/grant and captured-data bundle between the five mux sources and the
// round-robin arbiter that drives the shared 5-to-1 result mux select.
interface mux_sel_rr_arbiter_if #(
   parameter int DW = 4
);
   // Handshake: i_req[n] is a level held while source n wants beats.
   // A beat happens on every cycle where o_gnt[n] and i_req[n] are both 1.
   // The edge after a beat registers i_dat into o_dat and pulses o_dat_vld for one cycle.
   logic [4:0]    i_req;
   logic [DW-1:0] i_dat;
   logic [4:0]    o_gnt;
   logic [2:0]    o_ctrl;
   logic          o_busy;
   logic [DW-1:0] o_dat;
   logic          o_dat_vld;
   logic [2:0]    o_dat_id;

   modport master (
      output i_req, i_dat,
      input  o_gnt, o_ctrl, o_busy, o_dat, o_dat_vld, o_dat_id
   );

   modport slave (
      input  i_req, i_dat,
      output o_gnt, o_ctrl, o_busy, o_dat, o_dat_vld, o_dat_id
   );
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter for five sources sharing the 4-bit 5-to-1 result mux,
// with a per-grant burst limit and registered, source-tagged beat capture.
module mux_sel_rr_arbiter #(
   parameter int DW        = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   mux_sel_rr_arbiter_if.slave  bus,
   output logic                 dbg_state
);
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

   state_t        state_q, state_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [2:0]    owner_q, owner_d;
   logic [4:0]    gnt_q, gnt_d;
   logic [DW-1:0] dat_q, dat_d;
   logic          vld_q, vld_d;
   logic [2:0]    id_q, id_d;

   logic          owner_req;
   logic          beat;
   logic          rel;
   logic [2:0]    rot_ptr;
   logic [2:0]    scan_ptr;
   logic          win_found;
   logic [2:0]    win_idx;
   logic [3:0]    scan_sum;

   assign owner_req = bus.i_req[owner_q];
   assign beat      = (state_q == GRANT) && owner_req;
   assign rel       = (state_q == GRANT) && (!owner_req || (cnt_q == CNT_LAST));
   assign rot_ptr   = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
   // On release the scan already starts past the old owner, so a lone
   // requester is re-granted but any other requester takes precedence.
   assign scan_ptr  = rel ? rot_ptr : ptr_q;

   // Descending scan so the source closest to scan_ptr is written last and wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      scan_sum  = 4'd0;
      for (int i = 4; i >= 0; i--) begin
         scan_sum = {1'b0, scan_ptr} + 4'(i);
         if (scan_sum >= 4'd5) scan_sum = scan_sum - 4'd5;
         if (bus.i_req[scan_sum[2:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_sum[2:0];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         cnt_q   <= 4'd0;
         owner_q <= 3'd0;
         gnt_q   <= 5'd0;
         dat_q   <= '0;
         vld_q   <= 1'b0;
         id_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         dat_q   <= dat_d;
         vld_q   <= vld_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      dat_d   = dat_q;
      vld_d   = beat;
      id_d    = id_q;
      if (beat) begin
         dat_d = bus.i_dat;
         id_d  = owner_q;
         cnt_d = cnt_q + 4'd1;
      end
      if ((state_q == IDLE) || rel) begin
         ptr_d = scan_ptr;
         cnt_d = 4'd0;
         if (win_found) begin
            state_d = GRANT;
            owner_d = win_idx;
            gnt_d   = 5'b00001 << win_idx;
         end else begin
            state_d = IDLE;
            owner_d = 3'd0;
            gnt_d   = 5'd0;
         end
      end
   end

   always_comb begin
      bus.o_gnt     = gnt_q;
      bus.o_ctrl    = owner_q;
      bus.o_busy    = (state_q == GRANT);
      bus.o_dat     = dat_q;
      bus.o_dat_vld = vld_q;
      bus.o_dat_id  = id_q;
      dbg_state     = state_q;
   end
endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed bench for mux_sel_rr_arbiter: reset, single source, burst rotation,
// pointer wrap, early drop and mid-burst reset, with hand-computed expectations.
module tb_mux_sel_rr_arbiter;
   localparam int DW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dbg_state;
   int   n_vec = 0;
   int   n_bad = 0;

   mux_sel_rr_arbiter_if #(.DW(DW)) bus ();

   mux_sel_rr_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_ctl(input string tag, input logic [4:0] gnt, input logic [2:0] ctrl,
                          input logic busy, input logic vld);
      chk({tag, "_gnt"},  8'(bus.o_gnt),     8'(gnt));
      chk({tag, "_ctrl"}, 8'(bus.o_ctrl),    8'(ctrl));
      chk({tag, "_busy"}, 8'(bus.o_busy),    8'(busy));
      chk({tag, "_vld"},  8'(bus.o_dat_vld), 8'(vld));
   endtask

   task automatic exp_dat(input string tag, input logic [DW-1:0] dat, input logic [2:0] id);
      chk({tag, "_dat"}, 8'(bus.o_dat),    8'(dat));
      chk({tag, "_id"},  8'(bus.o_dat_id), 8'(id));
   endtask

   initial begin
      bus.i_req = 5'h1F;
      bus.i_dat = 4'hF;
      rst_n     = 1'b0;

      // reset held with every source requesting
      for (int k = 0; k < 3; k++) begin
         tick();
         exp_ctl("rst", 5'b00000, 3'd0, 1'b0, 1'b0);
         exp_dat("rst", 4'h0, 3'd0);
      end
      chk("rst_state", 8'(dbg_state), 8'd0);
      rst_n     = 1'b1;
      bus.i_req = 5'b00000;
      tick();
      exp_ctl("idle", 5'b00000, 3'd0, 1'b0, 1'b0);

      // single requester src2, three beats then drop
      bus.i_req = 5'b00100;
      bus.i_dat = 4'hA;
      tick();
      exp_ctl("t2_gnt", 5'b00100, 3'd2, 1'b1, 1'b0);
      for (int b = 0; b < 3; b++) begin
         bus.i_dat = 4'(5 + b);
         tick();
         exp_ctl("t2_beat", 5'b00100, 3'd2, 1'b1, 1'b1);
         exp_dat("t2_beat", 4'(5 + b), 3'd2);
      end
      bus.i_req = 5'b00000;
      bus.i_dat = 4'h9;
      tick();
      exp_ctl("t2_rel", 5'b00000, 3'd0, 1'b0, 1'b0);
      exp_dat("t2_hold", 4'h7, 3'd2);

      // burst limit: src0 and src1 alternate every 4 beats, ptr starts at 3
      bus.i_req = 5'b00011;
      tick();
      exp_ctl("t3_g0", 5'b00001, 3'd0, 1'b1, 1'b0);
      for (int b = 0; b < 4; b++) begin
         bus.i_dat = 4'(b + 1);
         tick();
         exp_ctl("t3_src0", (b == 3) ? 5'b00010 : 5'b00001, (b == 3) ? 3'd1 : 3'd0, 1'b1, 1'b1);
         exp_dat("t3_src0", 4'(b + 1), 3'd0);
      end
      for (int b = 0; b < 4; b++) begin
         bus.i_dat = 4'(b + 8);
         tick();
         exp_ctl("t3_src1", (b == 3) ? 5'b00001 : 5'b00010, (b == 3) ? 3'd0 : 3'd1, 1'b1, 1'b1);
         exp_dat("t3_src1", 4'(b + 8), 3'd1);
      end
      bus.i_req = 5'b00000;
      tick();
      exp_ctl("t3_idle", 5'b00000, 3'd0, 1'b0, 1'b0);

      // early drop: src3 falls after two beats while src1 waits
      bus.i_req = 5'b01000;
      tick();
      exp_ctl("t5_g3", 5'b01000, 3'd3, 1'b1, 1'b0);
      bus.i_req = 5'b01010;
      for (int b = 0; b < 2; b++) begin
         bus.i_dat = 4'(3 + b);
         tick();
         exp_ctl("t5_beat", 5'b01000, 3'd3, 1'b1, 1'b1);
         exp_dat("t5_beat", 4'(3 + b), 3'd3);
      end
      bus.i_req = 5'b00010;
      bus.i_dat = 4'hC;
      tick();
      exp_ctl("t5_drop", 5'b00010, 3'd1, 1'b1, 1'b0);
      exp_dat("t5_hold", 4'h4, 3'd3);
      bus.i_req = 5'b00000;
      tick();
      exp_ctl("t5_idle", 5'b00000, 3'd0, 1'b0, 1'b0);

      // park ptr at 4: grant src3 and release with no beat
      bus.i_req = 5'b01000;
      tick();
      exp_ctl("t4_pre", 5'b01000, 3'd3, 1'b1, 1'b0);
      bus.i_req = 5'b00000;
      tick();
      exp_ctl("t4_pre_idle", 5'b00000, 3'd0, 1'b0, 1'b0);

      // wrap: from ptr 4, src4 first, then src0, then back to src4
      bus.i_req = 5'b10001;
      tick();
      exp_ctl("t4_g4", 5'b10000, 3'd4, 1'b1, 1'b0);
      for (int b = 0; b < 4; b++) begin
         bus.i_dat = 4'(b + 2);
         tick();
         exp_ctl("t4_src4", (b == 3) ? 5'b00001 : 5'b10000, (b == 3) ? 3'd0 : 3'd4, 1'b1, 1'b1);
         exp_dat("t4_src4", 4'(b + 2), 3'd4);
      end
      for (int b = 0; b < 4; b++) begin
         bus.i_dat = 4'(b + 6);
         tick();
         exp_ctl("t4_src0", (b == 3) ? 5'b10000 : 5'b00001, (b == 3) ? 3'd4 : 3'd0, 1'b1, 1'b1);
         exp_dat("t4_src0", 4'(b + 6), 3'd0);
      end

      // src4 drops, src2 alone is re-granted after its burst with no bubble
      bus.i_req = 5'b00100;
      tick();
      exp_ctl("t6_g2", 5'b00100, 3'd2, 1'b1, 1'b0);
      for (int b = 0; b < 4; b++) begin
         bus.i_dat = 4'(b + 10);
         tick();
         exp_ctl("t6_src2", 5'b00100, 3'd2, 1'b1, 1'b1);
         exp_dat("t6_src2", 4'(b + 10), 3'd2);
      end

      // reset lands on a src2 beat: the beat is dropped
      rst_n     = 1'b0;
      bus.i_dat = 4'hF;
      tick();
      exp_ctl("t6_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
      exp_dat("t6_rst", 4'h0, 3'd0);
      rst_n     = 1'b1;
      bus.i_req = 5'b00110;
      tick();
      exp_ctl("t6_g1", 5'b00010, 3'd1, 1'b1, 1'b0);
      chk("t6_state", 8'(dbg_state), 8'd1);
      bus.i_req = 5'b00000;
      tick();
      exp_ctl("t6_idle", 5'b00000, 3'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
